// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests, buffers
// returned words and hands {instr, pc, pc+4} to decode; redirects flush everything in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = PW + 1;

  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];

  // head: oldest entry, fill: oldest unfilled entry, tail: next allocation
  logic [PW-1:0] head_ptr, fill_ptr, tail_ptr;
  logic [PW-1:0] squash_cnt;
  logic [31:0]   fetch_pc;
  logic          req_valid_q;

  logic [PW-1:0] alloc_cnt, unfilled_cnt;
  logic          req_fire, rsp_drop, rsp_fill, pop;
  logic [CW-1:0] alloc_next, squash_next;

  assign alloc_cnt    = tail_ptr - head_ptr;
  assign unfilled_cnt = tail_ptr - fill_ptr;
  assign req_fire     = req_valid_q & imem_req_ready;
  assign rsp_drop     = imem_rsp_valid & (squash_cnt != '0);
  assign rsp_fill     = imem_rsp_valid & (squash_cnt == '0);
  assign instr_valid  = (fill_ptr != head_ptr);
  assign pop          = instr_valid & instr_ready;

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc;

  assign instr          = instr_valid ? data_mem[head_ptr[IW-1:0]] : '0;
  assign instr_pc       = instr_valid ? pc_mem[head_ptr[IW-1:0]] : '0;
  assign instr_pc_plus4 = instr_valid ? instr_pc + 32'd4 : '0;

  // Credit accounting for the next cycle; a redirect turns every unfilled entry into a squash.
  always_comb begin
    alloc_next  = CW'(alloc_cnt) + CW'(req_fire) - CW'(pop);
    squash_next = CW'(squash_cnt) - CW'(rsp_drop);
    if (redirect_valid) begin
      alloc_next  = '0;
      squash_next = CW'(squash_cnt) + CW'(unfilled_cnt) + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr    <= '0;
      fill_ptr    <= '0;
      tail_ptr    <= '0;
      squash_cnt  <= '0;
      fetch_pc    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      req_valid_q <= (alloc_next + squash_next) < CW'(FIFO_DEPTH);
      squash_cnt  <= PW'(squash_next);
      if (redirect_valid) begin
        head_ptr <= '0;
        fill_ptr <= '0;
        tail_ptr <= '0;
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (req_fire) begin
          tail_ptr <= tail_ptr + PW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_fill) fill_ptr <= fill_ptr + PW'(1);
        if (pop)      head_ptr <= head_ptr + PW'(1);
      end
    end
  end

  // Entry payload carries no reset; visibility is governed by the pointers.
  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[tail_ptr[IW-1:0]]   <= fetch_pc;
    if (rsp_fill) data_mem[fill_ptr[IW-1:0]] <= imem_rsp_data;
  end

  assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (squash_cnt != '0 || unfilled_cnt != '0));
  assert property (@(posedge clk) disable iff (reset)
    (CW'(alloc_cnt) + CW'(squash_cnt)) <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: imem model with random latency/backpressure and a
// program-order scoreboard (sequential PC segments restarted at every redirect).
module tb_instr_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus4;

  int tests = 0, fails = 0, fire_count = 0, pop_count = 0, cyc = 0;
  int ready_pct = 100, ir_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t        pend[$];
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: in-order responses, latency lat_min..lat_max cycles after accept.
  initial begin
    int d;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    d = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        d = cyc + int'($urandom_range(lat_min, lat_max));
        if (pend.size() > 0 && d <= pend[$].due) d = pend[$].due + 1;
        pend.push_back('{addr: imem_req_addr, due: d});
      end
      @(posedge clk); #2;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Scoreboard / monitor: expected program order is a queue of sequential PCs per segment.
  initial begin
    logic [31:0] seg_next, exp_req, e, prev_pc, prev_instr, prev_addr;
    logic        have_prev, prev_redir, prev_istall, prev_rstall;
    seg_next = RST_PC; exp_req = RST_PC; have_prev = 1'b0;
    prev_pc = '0; prev_instr = '0; prev_addr = '0;
    prev_redir = 1'b0; prev_istall = 1'b0; prev_rstall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        seg_next  = RST_PC;
        exp_req   = RST_PC;
        have_prev = 1'b0;
      end else begin
        if (have_prev && !prev_redir) begin
          if (prev_istall) begin
            check("hold_instr_valid", 32'(instr_valid), 32'd1);
            check("hold_instr_pc", instr_pc, prev_pc);
            check("hold_instr", instr, prev_instr);
          end
          if (prev_rstall) begin
            check("hold_req_valid", 32'(imem_req_valid), 32'd1);
            check("hold_req_addr", imem_req_addr, prev_addr);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_req);
          exp_req += 32'd4;
          fire_count++;
        end
        if (instr_valid && instr_ready) begin
          while (exp_q.size() < DEPTH) begin
            exp_q.push_back(seg_next);
            seg_next += 32'd4;
          end
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr", instr, mem_word(e));
          check("instr_pc_plus4", instr_pc_plus4, e + 32'd4);
          pop_count++;
        end
        if (redirect_valid) begin
          exp_q.delete();
          seg_next = redirect_pc & 32'hFFFF_FFFC;
          exp_req  = seg_next;
        end
        prev_redir  = redirect_valid;
        prev_istall = instr_valid && !instr_ready;
        prev_rstall = imem_req_valid && !imem_req_ready;
        prev_pc     = instr_pc;
        prev_instr  = instr;
        prev_addr   = imem_req_addr;
        have_prev   = 1'b1;
      end
    end
  end

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
    return $urandom & 32'h0000_0FFF;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instr_ready = ($urandom_range(0, 99) < ir_pct);
      if ($urandom_range(0, 99) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = rand_target();
      end else begin
        redirect_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_instr_pc_plus4", instr_pc_plus4, 32'd0);
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    @(posedge clk); #1;
    instr_ready    = ($urandom_range(0, 99) < ir_pct);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    check("redir_flush", 32'(instr_valid), 32'd0);
    check("redir_addr", imem_req_addr, tgt & 32'hFFFF_FFFC);
  endtask

  // Stall decode until every credit is back, then drain with imem blocked: must yield DEPTH instrs.
  task automatic drain_check();
    int p0;
    redir_pct = 0; ir_pct = 0; ready_pct = 100;
    step(25);
    check("drain_req_valid", 32'(imem_req_valid), 32'd0);
    check("drain_instr_valid", 32'(instr_valid), 32'd1);
    ready_pct = 0; ir_pct = 100;
    p0 = pop_count;
    step(8);
    check("drain_pops", 32'(pop_count - p0), 32'(DEPTH));
    ready_pct = 100;
  endtask

  initial begin
    int p0, f0;
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // streaming at one instruction per cycle
    ready_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
    instr_ready = 1'b1;
    do_reset(3);
    p0 = pop_count;
    step(20);
    check("t1_throughput", 32'(pop_count - p0 >= 16), 32'd1);

    // decode stalled from reset: exactly DEPTH requests, then in-order delivery
    ir_pct = 0; instr_ready = 1'b0;
    do_reset(2);
    f0 = fire_count;
    step(12);
    check("t2_fires", 32'(fire_count - f0), 32'(DEPTH));
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_instr_valid", 32'(instr_valid), 32'd1);
    ready_pct = 0; ir_pct = 100;
    p0 = pop_count;
    step(8);
    check("t2_pops", 32'(pop_count - p0), 32'(DEPTH));

    // redirect with responses in flight, misaligned target, address wrap
    ready_pct = 100; lat_min = 2; lat_max = 2;
    step(10);
    do_redirect(32'h0000_0100);
    step(12);
    do_redirect(32'h0000_0203);
    step(10);
    do_redirect(32'hFFFF_FFFC);
    step(12);

    // redirect coinciding with pop, request and response
    lat_min = 1; lat_max = 1;
    step(10);
    do_redirect(32'h0000_0400);
    step(10);
    drain_check();

    // random traffic with random redirects
    lat_min = 1; lat_max = 3; ready_pct = 70; ir_pct = 60; redir_pct = 4;
    step(1500);
    drain_check();

    // reset with a full buffer and responses outstanding
    lat_min = 4; lat_max = 4; ready_pct = 100; ir_pct = 0;
    do_redirect(32'h0000_0800);
    step(6);
    do_reset(1);
    ir_pct = 100; lat_min = 1; lat_max = 1;
    step(15);
    drain_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
